// File: rtl/notif_pkg.sv
// Shared constants and width helpers for the notification arbiter.
package notif_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Channel-index width: at least one bit even for a single channel.
    function automatic int unsigned chan_width(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/notif_fifo.sv
// Per-channel synchronous FIFO; push ignored when full, pop ignored when empty.
module notif_fifo
    import notif_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW  = clog2(DEPTH);
    localparam int unsigned CNW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNW-1:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CNW'(do_push) - CNW'(do_pop);
        end
    end

endmodule

// File: rtl/notif_arbiter.sv
// Merges NCH masked event channels into one handshaked output stream.
module notif_arbiter
    import notif_pkg::*;
#(
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned MODE  = MODE_FIXED,
    localparam int unsigned CW    = chan_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       mask,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_chan,
    input  logic                 out_ready,
    output logic [NCH-1:0]       ovf,
    input  logic [NCH-1:0]       ovf_clr,
    output logic                 busy
);

    logic [NCH-1:0]   full;
    logic [NCH-1:0]   empty;
    logic [NCH-1:0]   push;
    logic [NCH-1:0]   pop;
    logic [NCH-1:0]   drop;
    logic [WIDTH-1:0] fifo_dout [NCH];
    logic [CW-1:0]    last_grant;
    logic [CW-1:0]    grant;
    logic             any_pending;
    logic             load;

    // Full is judged on the current count, so a same-cycle pop cannot rescue a write.
    assign push        = in_valid & ~mask & ~full;
    assign drop        = in_valid & ~mask & full;
    assign any_pending = |(~empty);
    assign load        = (~out_valid | out_ready) & any_pending;
    assign pop         = load ? (NCH'(1) << grant) : '0;
    assign busy        = out_valid | any_pending;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        notif_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (in_data[k*WIDTH +: WIDTH]),
            .dout  (fifo_dout[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    // Grant: first non-empty channel searching upward from the start point.
    always_comb begin
        int unsigned base;
        int unsigned idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        base  = (MODE == MODE_RR) ? ((32'(last_grant) + 32'd1) % NCH) : 32'd0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = (base + i) % NCH;
            if (!found && !empty[CW'(idx)]) begin
                grant = CW'(idx);
                found = 1'b1;
            end
        end
    end

    // Output register: loads when free or being accepted, holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= CW'(NCH - 1);
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= fifo_dout[grant];
            out_chan   <= grant;
            last_grant <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Sticky overflow flags; a new drop beats a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~ovf_clr) | drop;
        end
    end

endmodule

// File: tb/tb_notif_arbiter.sv
// Directed bench for notif_arbiter: fixed-priority and round-robin instances share stimulus.
module tb_notif_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  mask;
    logic        out_ready;
    logic [3:0]  ovf_clr;

    logic        fp_valid, rr_valid;
    logic [3:0]  fp_data, rr_data;
    logic [1:0]  fp_chan, rr_chan;
    logic [3:0]  fp_ovf, rr_ovf;
    logic        fp_busy, rr_busy;

    int checks;
    int errors;

    notif_arbiter #(.NCH(4), .WIDTH(4), .DEPTH(4), .MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mask(mask),
        .out_valid(fp_valid), .out_data(fp_data), .out_chan(fp_chan), .out_ready(out_ready),
        .ovf(fp_ovf), .ovf_clr(ovf_clr), .busy(fp_busy)
    );

    notif_arbiter #(.NCH(4), .WIDTH(4), .DEPTH(4), .MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mask(mask),
        .out_valid(rr_valid), .out_data(rr_data), .out_chan(rr_chan), .out_ready(out_ready),
        .ovf(rr_ovf), .ovf_clr(ovf_clr), .busy(rr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; in_data = '0; mask = '0; out_ready = 1'b0; ovf_clr = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fp_valid, fp_data, fp_chan, fp_ovf, fp_busy} !== 12'h0) begin
            errors++;
            $display("FAIL reset_fp: got v=%b d=%h c=%0d ovf=%b busy=%b, exp all zero", fp_valid, fp_data, fp_chan, fp_ovf, fp_busy);
        end
        checks++;
        if ({rr_valid, rr_data, rr_chan, rr_ovf, rr_busy} !== 12'h0) begin
            errors++;
            $display("FAIL reset_rr: got v=%b d=%h c=%0d ovf=%b busy=%b, exp all zero", rr_valid, rr_data, rr_chan, rr_ovf, rr_busy);
        end
        in_valid = 4'b0100; in_data = 16'h0A00;
        tick();
        in_valid = '0; in_data = '0;
        checks++;
        if ({fp_valid, fp_busy} !== 2'b01) begin
            errors++;
            $display("FAIL latency_cycle1: got v=%b busy=%b, exp v=0 busy=1", fp_valid, fp_busy);
        end
        tick();
        checks++;
        if ({fp_valid, fp_data, fp_chan} !== {1'b1, 4'hA, 2'd2}) begin
            errors++;
            $display("FAIL latency_cycle2_fp: got v=%b d=%h c=%0d, exp v=1 d=a c=2", fp_valid, fp_data, fp_chan);
        end
        checks++;
        if ({rr_valid, rr_data, rr_chan} !== {1'b1, 4'hA, 2'd2}) begin
            errors++;
            $display("FAIL latency_cycle2_rr: got v=%b d=%h c=%0d, exp v=1 d=a c=2", rr_valid, rr_data, rr_chan);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({fp_valid, fp_busy, rr_valid, rr_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_accept: got fp v=%b b=%b rr v=%b b=%b, exp all 0", fp_valid, fp_busy, rr_valid, rr_busy);
        end
    endtask

    task automatic test_fixed_priority();
        logic [3:0] ed [3];
        logic [1:0] ec [3];
        ed = '{4'h1, 4'h2, 4'h3};
        ec = '{2'd0, 2'd1, 2'd3};
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'b1011; in_data = 16'h3021;
        tick();
        in_valid = '0; in_data = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({fp_valid, fp_data, fp_chan} !== {1'b1, ed[i], ec[i]}) begin
                errors++;
                $display("FAIL fixed_prio[%0d]: got v=%b d=%h c=%0d, exp v=1 d=%h c=%0d", i, fp_valid, fp_data, fp_chan, ed[i], ec[i]);
            end
        end
        tick();
        checks++;
        if (fp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fixed_prio_end: got v=%b, exp 0", fp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] ed;
        logic [1:0] ec;
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'hF; in_data = 16'h3210;
        tick();
        in_data = 16'h7654;
        tick();
        in_valid = '0; in_data = '0;
        for (int i = 0; i < 8; i++) begin
            ed = 4'(i);
            ec = 2'(i % 4);
            checks++;
            if ({rr_valid, rr_data, rr_chan} !== {1'b1, ed, ec}) begin
                errors++;
                $display("FAIL round_robin[%0d]: got v=%b d=%h c=%0d, exp v=1 d=%h c=%0d", i, rr_valid, rr_data, rr_chan, ed, ec);
            end
            ed = 4'((i % 2) * 4 + i / 2);
            ec = 2'(i / 2);
            checks++;
            if ({fp_valid, fp_data, fp_chan} !== {1'b1, ed, ec}) begin
                errors++;
                $display("FAIL fixed_drain[%0d]: got v=%b d=%h c=%0d, exp v=1 d=%h c=%0d", i, fp_valid, fp_data, fp_chan, ed, ec);
            end
            tick();
        end
        checks++;
        if ({rr_valid, rr_busy} !== 2'b00) begin
            errors++;
            $display("FAIL round_robin_end: got v=%b busy=%b, exp 0 0", rr_valid, rr_busy);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 4'b0010; in_data = 16'((i + 1) << 4);
            tick();
            if (i == 4) begin
                checks++;
                if (fp_ovf !== 4'b0000) begin
                    errors++;
                    $display("FAIL ovf_before_drop: got %b, exp 0000", fp_ovf);
                end
            end
        end
        in_valid = '0; in_data = '0;
        checks++;
        if ({fp_ovf, rr_ovf} !== 8'b0010_0010) begin
            errors++;
            $display("FAIL ovf_set: got fp=%b rr=%b, exp 0010", fp_ovf, rr_ovf);
        end
        tick();
        checks++;
        if (fp_ovf !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, exp 0010", fp_ovf);
        end
        in_valid = 4'b0010; in_data = 16'h0070; ovf_clr = 4'b0010;
        tick();
        in_valid = '0; in_data = '0; ovf_clr = '0;
        checks++;
        if (fp_ovf !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b, exp 0010", fp_ovf);
        end
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = '0;
        checks++;
        if ({fp_ovf, rr_ovf} !== 8'h00) begin
            errors++;
            $display("FAIL ovf_clear: got fp=%b rr=%b, exp 0000", fp_ovf, rr_ovf);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({fp_valid, fp_data, fp_chan} !== {1'b1, 4'(i + 1), 2'd1}) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got v=%b d=%h c=%0d, exp v=1 d=%h c=1", i, fp_valid, fp_data, fp_chan, 4'(i + 1));
            end
            tick();
        end
        checks++;
        if ({fp_valid, fp_busy} !== 2'b00) begin
            errors++;
            $display("FAIL ovf_drain_end: got v=%b busy=%b, exp 0 0", fp_valid, fp_busy);
        end
    endtask

    task automatic test_mask_backpressure();
        logic [3:0]  exp_d [3];
        logic [1:0]  exp_c [3];
        logic [11:0] pat;
        logic [3:0]  held;
        logic        stalled;
        int          ptr;
        exp_d = '{4'h9, 4'hA, 4'h5};
        exp_c = '{2'd0, 2'd0, 2'd2};
        pat = 12'b0110_1010_0100;
        stalled = 1'b0;
        held = '0;
        ptr = 0;
        do_reset();
        in_valid = 4'b0001; in_data = 16'h0009;
        tick();
        in_data = 16'h000A;
        tick();
        mask = 4'b0001; in_valid = 4'b0101; in_data = 16'h050F;
        tick();
        in_valid = '0; in_data = '0;
        checks++;
        if (fp_ovf !== 4'b0000) begin
            errors++;
            $display("FAIL mask_no_ovf: got %b, exp 0000", fp_ovf);
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = pat[cyc];
            if (stalled) begin
                checks++;
                if ({fp_valid, fp_data} !== {1'b1, held}) begin
                    errors++;
                    $display("FAIL stall_stable[%0d]: got v=%b d=%h, exp v=1 d=%h", cyc, fp_valid, fp_data, held);
                end
            end
            if (fp_valid && out_ready) begin
                checks++;
                if (ptr >= 3) begin
                    errors++;
                    $display("FAIL mask_extra[%0d]: got d=%h c=%0d, exp no further output", cyc, fp_data, fp_chan);
                end else if ({fp_data, fp_chan} !== {exp_d[ptr], exp_c[ptr]}) begin
                    errors++;
                    $display("FAIL mask_order[%0d]: got d=%h c=%0d, exp d=%h c=%0d", ptr, fp_data, fp_chan, exp_d[ptr], exp_c[ptr]);
                end
                ptr++;
            end
            stalled = fp_valid & ~out_ready;
            held = fp_data;
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (ptr != 3) begin
            errors++;
            $display("FAIL mask_count: got %0d outputs, exp 3", ptr);
        end
        checks++;
        if ({fp_valid, fp_busy} !== 2'b00) begin
            errors++;
            $display("FAIL mask_end: got v=%b busy=%b, exp 0 0", fp_valid, fp_busy);
        end
        mask = '0;
    endtask

    task automatic test_midstream_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid = 4'b1011; in_data = 16'h3021;
        tick();
        in_valid = '0; in_data = '0;
        tick();
        rst = 1'b1; in_valid = 4'b0100; in_data = 16'h0E00;
        tick();
        rst = 1'b0; in_valid = '0; in_data = '0;
        checks++;
        if ({fp_valid, fp_busy, rr_valid, rr_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_clear: got fp v=%b b=%b rr v=%b b=%b, exp all 0", fp_valid, fp_busy, rr_valid, rr_busy);
        end
        tick();
        checks++;
        if ({fp_valid, fp_busy} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_ignored_input: got v=%b busy=%b, exp 0 0", fp_valid, fp_busy);
        end
        out_ready = 1'b1;
        in_valid = 4'b1000; in_data = 16'hC000;
        tick();
        in_valid = '0; in_data = '0;
        checks++;
        if (fp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_lat1: got v=%b, exp 0", fp_valid);
        end
        tick();
        checks++;
        if ({fp_valid, fp_data, fp_chan} !== {1'b1, 4'hC, 2'd3}) begin
            errors++;
            $display("FAIL midreset_lat2: got v=%b d=%h c=%0d, exp v=1 d=c c=3", fp_valid, fp_data, fp_chan);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; in_valid = '0; in_data = '0; mask = '0; out_ready = 1'b0; ovf_clr = '0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_overflow();
        test_mask_backpressure();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/notif_arbiter.md
# notif_arbiter

Parametrised successor to the fixed three-source notification path that feeds the LED manager. Merges NCH independent event channels into one handshaked output stream. Each channel has its own small synchronous FIFO, per-channel masking and a sticky overflow flag. Selection uses either fixed priority or round-robin, set by parameter. Sits between the UART/CM/VGA status producers and the LED manager, all on one clock domain.

## Interface
- NCH, 4: number of input channels, 2..8
- WIDTH, 4: event code width, 1..16
- DEPTH, 4: per-channel FIFO depth, power of two, ≥2
- MODE, 0: 0 = fixed priority (ch0 highest), 1 = round-robin
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  NCH  per-channel event strobe, one event per cycle per channel
- in_data  in  NCH*WIDTH  event codes; channel k occupies bits [k*WIDTH +: WIDTH]
- mask  in  NCH  1 = channel writes ignored (debug gating)
- out_valid  out  1  output register holds an event
- out_data  out  WIDTH  event code
- out_chan  out  max(1,clog2(NCH))  source channel of out_data
- out_ready  in  1  consumer accepts when out_valid & out_ready
- ovf  out  NCH  sticky: an event was dropped on that channel
- ovf_clr  in  NCH  per-bit clear of ovf
- busy  out  1  out_valid OR any FIFO non-empty

## Operation
- Write: channel k pushes in_data[k] when in_valid[k] & ~mask[k] & ~full[k].
  - in_valid[k] & ~mask[k] & full[k]: event dropped, ovf[k] set.
  - full[k] is evaluated on the current count, so a pop in the same cycle does not rescue the write.
- Mask blocks writes only. Entries already queued still drain.
- Load condition: the output register loads when (~out_valid | out_ready) and at least one FIFO is non-empty.
  - The granted FIFO pops in that same cycle.
  - If no FIFO is non-empty, out_valid clears on acceptance.
- Grant selection:
  - MODE 0: lowest-index non-empty channel.
  - MODE 1: first non-empty channel searching upward from (last_grant+1) mod NCH. last_grant updates only on a load.
- Stall: out_data and out_chan are stable while out_valid & ~out_ready.
- Simultaneous push and pop on the same non-full FIFO: count unchanged, both happen.
- Overflow flag: ovf_clr[k] in the same cycle as a new overflow on k leaves ovf[k] = 1 (set wins).
- State per channel: rd_ptr, wr_ptr, count (0..DEPTH). Pointers wrap modulo DEPTH.

## Timing
- Reset (rst high at an edge) gives:
  - out_valid = 0, out_data = 0, out_chan = 0
  - ovf = 0, busy = 0
  - all FIFOs empty, last_grant = NCH-1
- Reset mid-operation discards all queued and held events. Inputs are ignored while rst is high.
- Latency: event presented in cycle 0 on an idle block → out_valid = 1 in cycle 2 (FIFO write at edge 1, output load at edge 2).
- Throughput: one event per cycle with out_ready held high.
- Capacity: DEPTH+1 events per channel may be in flight (FIFO plus output register).
- ovf[k] rises the cycle after the dropped write.
- busy is combinational from registered state.

## Structure
- Package notif_pkg:
  - MODE_FIXED = 0, MODE_RR = 1
  - clog2 helper function
  - channel-index width derivation
- Sub-module notif_fifo: parametrised WIDTH/DEPTH synchronous FIFO.
  - Ports: push, pop, data in/out, full, empty.
  - Instantiated NCH times via generate.
- Arbiter, output register and ovf flags live in notif_arbiter itself.

## Test plan
- Reset/idle: rst for 2 cycles → all outputs 0. Ch2 writes 4'hA in cycle 0 → out_valid=1, out_data=A, out_chan=2 in cycle 2.
- Fixed priority (MODE 0): ch0=1, ch1=2, ch3=3 written in the same cycle, out_ready=1 → outputs 1, 2, 3 on consecutive cycles.
- Round-robin (MODE 1): all 4 channels each queue 2 events, out_ready=1 → channel order 0,1,2,3,0,1,2,3.
- Overflow: out_ready=0, ch1 receives DEPTH+2=6 events → 5 retained (1 in output register, 4 in FIFO), 1 dropped.
  - ovf[1]=1 and stays set. ovf_clr[1] pulse → ovf[1]=0.
  - ovf_clr[1] coincident with a new drop → ovf[1] stays 1.
- Mask and backpressure: mask[0]=1, ch0 writes ignored while its prior entries still drain. out_ready toggling 1/0 → out_data stable while stalled, no loss or duplication.
- Mid-stream reset: rst while 3 events are queued → next cycle out_valid=0, busy=0. A later event emerges with the normal 2-cycle latency.
